i2s_dac_tx: RTL and testbench



---
 rtl/audio_i2s_pkg.sv | 16 +
 rtl/i2s_clkgen.sv | 50 +++++
 rtl/i2s_dac_tx.sv | 119 +++++++++++
 tb/tb_i2s_dac_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared constants and types for the I2S DAC transmitter.
//   SLOT_BITS / FRAME_BITS : I2S slot and frame length in bit clocks
//   DATA_W_DEF / BCLK_DIV_DEF : default sample width and clk cycles per BCLK
//   DIV_W   : divider counter width for the default BCLK_DIV
//   pcm_t   : signed PCM sample at the default width
package audio_i2s_pkg;

    localparam int unsigned SLOT_BITS    = 32;
    localparam int unsigned FRAME_BITS   = 64;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned BCLK_DIV_DEF = 16;
    localparam int unsigned DIV_W        = $clog2(BCLK_DIV_DEF);

    typedef logic signed [DATA_W_DEF-1:0] pcm_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Clock generation for the I2S transmitter.
//   clk       : system clock (50 MHz)
//   reset     : synchronous, active-high
//   mclk      : codec master clock, clk/2, free-running
//   sclk      : bit clock, low for the first half of the divider period
//   fall_tick : high on the clk whose closing edge makes sclk fall
module i2s_clkgen
    import audio_i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic mclk,
    output logic sclk,
    output logic fall_tick
);

    localparam int unsigned CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BCLK_DIV / 2);

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_n;

    // Divider next value: 0..BCLK_DIV-1 then wrap
    always_comb begin
        div_cnt_n = div_cnt + CNT_W'(1);
        if (div_cnt == CNT_MAX) begin
            div_cnt_n = '0;
        end
    end

    // sclk and fall_tick are decoded from the next count so they line up
    // with div_cnt rather than lagging it by one clk
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            mclk      <= 1'b0;
            sclk      <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            div_cnt   <= div_cnt_n;
            mclk      <= ~mclk;
            sclk      <= (div_cnt_n >= CNT_HALF);
            fall_tick <= (div_cnt_n == CNT_MAX);
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Standard-format I2S transmitter for the codec DAC path.
//   clk_50MHz  : system clock
//   reset      : synchronous, active-high
//   L_data     : left PCM sample, captured at frame start
//   R_data     : right PCM sample, captured at frame start
//   mute       : silences the frame that starts next
//   sample_ack : one-clk pulse when L_data/R_data are captured
//   dac_MCLK   : clk/2 master clock
//   dac_SCLK   : bit clock (clk/BCLK_DIV)
//   dac_LRCK   : word select, 0 = left slot, 1 = right slot
//   dac_SDIN   : serial data, MSB first, one bit clock after LRCK changes
module i2s_dac_tx
    import audio_i2s_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] L_data,
    input  logic [DATA_W-1:0] R_data,
    input  logic              mute,
    output logic              sample_ack,
    output logic              dac_MCLK,
    output logic              dac_SCLK,
    output logic              dac_LRCK,
    output logic              dac_SDIN
);

    localparam int unsigned BP_W = $clog2(FRAME_BITS);
    localparam int unsigned K_W  = $clog2(SLOT_BITS);
    localparam logic [BP_W-1:0] FRAME_LAST = BP_W'(FRAME_BITS - 1);

    logic              fall_tick;

    logic [BP_W-1:0]   bitpos,   bitpos_n;
    logic [DATA_W-1:0] shadow_l, shadow_l_n;
    logic [DATA_W-1:0] shadow_r, shadow_r_n;
    logic              mute_lat, mute_n;
    logic [DATA_W-1:0] shift_q,  shift_n;
    logic              sdin_n;
    logic              lrck_n;
    logic              ack_n;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk       (clk_50MHz),
        .reset     (reset),
        .mclk      (dac_MCLK),
        .sclk      (dac_SCLK),
        .fall_tick (fall_tick)
    );

    // Serial state advances only on the SCLK falling edge
    always_comb begin
        bitpos_n   = bitpos;
        shadow_l_n = shadow_l;
        shadow_r_n = shadow_r;
        mute_n     = mute_lat;
        shift_n    = shift_q;
        sdin_n     = dac_SDIN;
        lrck_n     = dac_LRCK;
        ack_n      = 1'b0;

        if (fall_tick) begin
            bitpos_n = bitpos + BP_W'(1);
            lrck_n   = bitpos_n[BP_W-1];

            // Capture both channels together so a frame is never split
            if (bitpos == FRAME_LAST) begin
                shadow_l_n = L_data;
                shadow_r_n = R_data;
                mute_n     = mute;
                ack_n      = 1'b1;
            end

            // Slot bit 0 carries the one-bit I2S delay; the word is loaded
            // here and shifted out from bit 1, zeros fill the slot tail
            if (bitpos_n[K_W-1:0] == '0) begin
                sdin_n = 1'b0;
                if (mute_n) begin
                    shift_n = '0;
                end else if (bitpos_n[BP_W-1]) begin
                    shift_n = shadow_r_n;
                end else begin
                    shift_n = shadow_l_n;
                end
            end else begin
                sdin_n  = shift_q[DATA_W-1];
                shift_n = {shift_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Serial state registers
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            bitpos     <= '0;
            shadow_l   <= '0;
            shadow_r   <= '0;
            mute_lat   <= 1'b0;
            shift_q    <= '0;
            dac_SDIN   <= 1'b0;
            dac_LRCK   <= 1'b0;
            sample_ack <= 1'b0;
        end else begin
            bitpos     <= bitpos_n;
            shadow_l   <= shadow_l_n;
            shadow_r   <= shadow_r_n;
            mute_lat   <= mute_n;
            shift_q    <= shift_n;
            dac_SDIN   <= sdin_n;
            dac_LRCK   <= lrck_n;
            sample_ack <= ack_n;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a default build (BCLK_DIV=16) and a BCLK_DIV=4 build
// share one stimulus. Expected serial bits are pushed per frame into a queue
// at each capture instant and popped at every SCLK rising edge.
module tb_i2s_dac_tx;

    localparam int D0 = 16;
    localparam int D1 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] l_data = '0;
    logic [15:0] r_data = '0;
    logic        mute = 1'b0;

    logic ack0, mclk0, sclk0, lrck0, sdin0;
    logic ack1, mclk1, sclk1, lrck1, sdin1;

    int n_checks = 0;
    int n_fail   = 0;
    int t0 = 0;
    int t1 = 0;
    logic q0[$];
    logic q1[$];

    always #10 clk = ~clk;

    i2s_dac_tx #(.DATA_W(16), .BCLK_DIV(D0)) u_dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .L_data    (l_data),
        .R_data    (r_data),
        .mute      (mute),
        .sample_ack(ack0),
        .dac_MCLK  (mclk0),
        .dac_SCLK  (sclk0),
        .dac_LRCK  (lrck0),
        .dac_SDIN  (sdin0)
    );

    i2s_dac_tx #(.DATA_W(16), .BCLK_DIV(D1)) u_dut4 (
        .clk_50MHz (clk),
        .reset     (reset),
        .L_data    (l_data),
        .R_data    (r_data),
        .mute      (mute),
        .sample_ack(ack1),
        .dac_MCLK  (mclk1),
        .dac_SCLK  (sclk1),
        .dac_LRCK  (lrck1),
        .dac_SDIN  (sdin1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected SDIN for slot bits 0..63 of a frame carrying l/r
    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r,
                                                input logic m);
        logic [63:0] bits;
        logic [15:0] s;
        int k;
        bits = '0;
        for (int b = 0; b < 64; b++) begin
            k = b % 32;
            s = (b < 32) ? l : r;
            if (!m && k >= 1 && k <= 16) bits[b] = s[16-k];
        end
        return bits;
    endfunction

    task automatic push_bits(input int inst, input logic [63:0] bits);
        for (int b = 0; b < 64; b++) begin
            if (inst == 0) q0.push_back(bits[b]);
            else           q1.push_back(bits[b]);
        end
    endtask

    task automatic model_reset(input int inst, input logic mclk, input logic sclk,
                               input logic lrck, input logic sdin, input logic ack);
        string p;
        p = (inst == 0) ? "d16" : "d4";
        if (inst == 0) q0.delete();
        else           q1.delete();
        // Frame after reset runs from bitpos 0 with zeroed shadows
        push_bits(inst, 64'h0);
        check_val({p, "_rst_outs"}, 32'({mclk, sclk, lrck, sdin, ack}), 32'h0);
    endtask

    // t = clk edges since reset release
    task automatic model_step(input int inst, input int d, input int t,
                              input logic mclk, input logic sclk, input logic lrck,
                              input logic sdin, input logic ack);
        string p;
        int    div;
        int    bp;
        logic  exp_bit;
        p   = (inst == 0) ? "d16" : "d4";
        div = t % d;
        bp  = (t / d) % 64;
        check_val({p, "_mclk"}, 32'(mclk), 32'(t % 2));
        check_val({p, "_sclk"}, 32'(sclk), 32'(div >= d / 2));
        check_val({p, "_lrck"}, 32'(lrck), 32'(bp >= 32));
        check_val({p, "_ack"},  32'(ack),  32'(t % (64 * d) == 0));
        if (t % (64 * d) == 0)
            push_bits(inst, frame_bits(l_data, r_data, mute));
        if (div == d / 2) begin
            if ((inst == 0 && q0.size() == 0) || (inst != 0 && q1.size() == 0)) begin
                check_val({p, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                exp_bit = (inst == 0) ? q0.pop_front() : q1.pop_front();
                check_val($sformatf("%s_sdin_bit%0d", p, bp), 32'(sdin), 32'(exp_bit));
            end
        end
    endtask

    // Monitor: sample 1 time unit after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                t0 = 0;
                t1 = 0;
                model_reset(0, mclk0, sclk0, lrck0, sdin0, ack0);
                model_reset(1, mclk1, sclk1, lrck1, sdin1, ack1);
            end else begin
                t0++;
                t1++;
                model_step(0, D0, t0, mclk0, sclk0, lrck0, sdin0, ack0);
                model_step(1, D1, t1, mclk1, sclk1, lrck1, sdin1, ack1);
            end
        end
    end

    task automatic wait_t(input int n);
        int g;
        g = 0;
        while (t0 < n && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (t0 < n) check_val("wait_t_timeout", 32'(t0), 32'(n));
    endtask

    initial begin
        reset  = 1'b1;
        l_data = 16'hA5C3;
        r_data = 16'h0F0F;
        mute   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Frame 0 zeros, frame 1 (capture at 1024) A5C3 / 0F0F
        wait_t(1500);
        l_data = 16'h8000;
        // Change during bitpos 10 of frame 2: frame 2 keeps 8000, frame 3 sends 7FFF
        wait_t(2048 + 10 * D0);
        l_data = 16'h7FFF;

        // Frame 4 muted, frame 5 sends FFFF in both slots
        wait_t(3500);
        l_data = 16'hFFFF;
        r_data = 16'hFFFF;
        mute   = 1'b1;
        wait_t(4096 + 100);
        mute = 1'b0;

        // One-clk reset at bitpos 40 of frame 5
        wait_t(5120 + 40 * D0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Zero frame then one full data frame
        wait_t(2048 + 200);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
